// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU command front-end: opcodes, issuer FSM states
// and the number of cycles during which a stale FpuDone is ignored after a load.
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int GUARD_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    GUARD = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } issuer_state_t;

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Synchronous command FIFO. Full/Empty come from a registered occupancy count;
// pushes while full and pops while empty are dropped.
module fpu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             Push,
  input  logic [WIDTH-1:0] PushData,
  input  logic             Pop,
  output logic [WIDTH-1:0] PopData,
  output logic             Full,
  output logic             Empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] COUNT_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [PW:0]      count;
  logic             doPush;
  logic             doPop;

  assign doPush = Push && !Full;
  assign doPop  = Pop && !Empty;

  // Pointers are exactly PW bits wide, so incrementing wraps modulo DEPTH.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (doPush) mem[wrPtr] <= PushData;
  end

  assign PopData = mem[rdPtr];
  assign Full    = (count == COUNT_FULL);
  assign Empty   = (count == '0);

endmodule

// File: rtl/fpu_cmd_issuer.sv
// Host-side sequencer for the FPU: queues commands, issues one load pulse per
// command, masks stale Done, times out stuck operations and returns tagged results.
module fpu_cmd_issuer
  import fpu_pkg::*;
#(
  parameter int PRECISION = 32,
  parameter int DEPTH     = 4,
  parameter int TAG_W     = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  input  logic                 CmdValid,
  output logic                 CmdReady,
  input  logic [PRECISION-1:0] CmdA,
  input  logic [PRECISION-1:0] CmdB,
  input  logic [1:0]           CmdOp,
  input  logic [TAG_W-1:0]     CmdTag,
  output logic [PRECISION-1:0] FpuA,
  output logic [PRECISION-1:0] FpuB,
  output logic [1:0]           FpuOperation,
  output logic                 FpuStart,
  input  logic [PRECISION-1:0] FpuResult,
  input  logic                 FpuDone,
  output logic                 RspValid,
  input  logic                 RspReady,
  output logic [PRECISION-1:0] RspResult,
  output logic [TAG_W-1:0]     RspTag,
  output logic                 RspTimeout,
  output logic                 Busy,
  output issuer_state_t        DbgState
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; a valid source holds its payload stable until that edge.
  localparam int FW    = 2*PRECISION + 2 + TAG_W;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]       GUARD_LAST = 2'(GUARD_CYCLES - 1);

  issuer_state_t    state, stateNext;
  logic [1:0]       guardCnt, guardNext;
  logic [CNT_W-1:0] waitCnt, waitNext;
  logic             pop, capture, timeoutHit;
  logic             fifoFull, fifoEmpty;
  logic [FW-1:0]    fifoHead;

  assign CmdReady = !fifoFull;
  assign Busy     = (state != IDLE) || !fifoEmpty;
  assign DbgState = state;

  fpu_cmd_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) uFifo (
    .Clk      (Clk),
    .ResetN   (ResetN),
    .Push     (CmdValid && CmdReady),
    .PushData ({CmdA, CmdB, CmdOp, CmdTag}),
    .Pop      (pop),
    .PopData  (fifoHead),
    .Full     (fifoFull),
    .Empty    (fifoEmpty)
  );

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state    <= IDLE;
      guardCnt <= '0;
      waitCnt  <= '0;
    end else begin
      state    <= stateNext;
      guardCnt <= guardNext;
      waitCnt  <= waitNext;
    end
  end

  always_comb begin
    stateNext  = state;
    guardNext  = guardCnt;
    waitNext   = waitCnt;
    pop        = 1'b0;
    capture    = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      IDLE: if (!fifoEmpty) begin
        pop       = 1'b1;
        stateNext = START;
      end
      START: begin
        guardNext = '0;
        stateNext = GUARD;
      end
      GUARD: if (guardCnt == GUARD_LAST) begin
        waitNext  = '0;
        stateNext = WAIT;
      end else begin
        guardNext = guardCnt + 1'b1;
      end
      // A genuine Done takes priority over a coincident timeout.
      WAIT: if (FpuDone) begin
        capture   = 1'b1;
        stateNext = RESP;
      end else if (waitCnt == WAIT_LAST) begin
        timeoutHit = 1'b1;
        stateNext  = RESP;
      end else begin
        waitNext = waitCnt + 1'b1;
      end
      RESP: if (RspReady) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      FpuA         <= '0;
      FpuB         <= '0;
      FpuOperation <= '0;
      FpuStart     <= 1'b0;
      RspValid     <= 1'b0;
      RspResult    <= '0;
      RspTag       <= '0;
      RspTimeout   <= 1'b0;
    end else begin
      FpuStart <= (stateNext == START);
      RspValid <= (stateNext == RESP);
      if (pop) {FpuA, FpuB, FpuOperation, RspTag} <= fifoHead;
      if (capture) begin
        RspResult  <= FpuResult;
        RspTimeout <= 1'b0;
      end else if (timeoutHit) begin
        RspResult  <= '0;
        RspTimeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_cmd_issuer.sv
// Directed bench for fpu_cmd_issuer with a behavioural FPU stand-in that supports
// normal operation, Done stuck high and Done stuck low.
module tb_fpu_cmd_issuer;
  import fpu_pkg::*;

  localparam int PRECISION = 32;
  localparam int DEPTH     = 4;
  localparam int TAG_W     = 4;
  localparam int TIMEOUT   = 16;

  // clock / reset
  logic Clk = 1'b0;
  logic ResetN = 1'b0;
  always #5 Clk = ~Clk;

  logic                 CmdValid = 1'b0;
  logic                 CmdReady;
  logic [PRECISION-1:0] CmdA = '0;
  logic [PRECISION-1:0] CmdB = '0;
  logic [1:0]           CmdOp = '0;
  logic [TAG_W-1:0]     CmdTag = '0;
  logic [PRECISION-1:0] FpuA;
  logic [PRECISION-1:0] FpuB;
  logic [1:0]           FpuOperation;
  logic                 FpuStart;
  logic [PRECISION-1:0] FpuResult = '0;
  logic                 FpuDone = 1'b0;
  logic                 RspValid;
  logic                 RspReady = 1'b0;
  logic [PRECISION-1:0] RspResult;
  logic [TAG_W-1:0]     RspTag;
  logic                 RspTimeout;
  logic                 Busy;
  issuer_state_t        DbgState;

  fpu_cmd_issuer #(
    .PRECISION(PRECISION), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk(Clk), .ResetN(ResetN),
    .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdA(CmdA), .CmdB(CmdB), .CmdOp(CmdOp), .CmdTag(CmdTag),
    .FpuA(FpuA), .FpuB(FpuB), .FpuOperation(FpuOperation), .FpuStart(FpuStart),
    .FpuResult(FpuResult), .FpuDone(FpuDone),
    .RspValid(RspValid), .RspReady(RspReady),
    .RspResult(RspResult), .RspTag(RspTag), .RspTimeout(RspTimeout),
    .Busy(Busy), .DbgState(DbgState)
  );

  // FPU stand-in: loads on the falling edge inside the start pulse, forces Done low,
  // then raises Done after an op-dependent number of falling edges and holds it.
  int          stubMode = 0;
  int          stubCnt = 0;
  logic [31:0] ldA = '0;
  logic [31:0] ldB = '0;
  logic [1:0]  ldOp = '0;

  function automatic int latOf(input logic [1:0] op);
    case (op)
      OP_ADD:  return 4;
      OP_SUB:  return 5;
      OP_MUL:  return 3;
      default: return 8;
    endcase
  endfunction

  function automatic logic [31:0] fpuModel(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case ({op, a, b})
      {OP_ADD, 32'h3F800000, 32'h40000000}: return 32'h40400000;
      {OP_SUB, 32'h40400000, 32'h3F800000}: return 32'h40000000;
      {OP_MUL, 32'h40000000, 32'h40400000}: return 32'h40C00000;
      {OP_DIV, 32'h40C00000, 32'h40000000}: return 32'h40400000;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  always @(negedge Clk) begin
    if (stubMode == 1) begin
      FpuDone   = 1'b1;
      FpuResult = 32'h0BADF00D;
    end else if (stubMode == 2) begin
      FpuDone = 1'b0;
    end else if (FpuStart) begin
      ldA = FpuA; ldB = FpuB; ldOp = FpuOperation;
      FpuDone = 1'b0;
      stubCnt = latOf(FpuOperation);
    end else if (stubCnt > 1) begin
      stubCnt = stubCnt - 1;
    end else if (stubCnt == 1) begin
      stubCnt   = 0;
      FpuDone   = 1'b1;
      FpuResult = fpuModel(ldOp, ldA, ldB);
    end
  end

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [PRECISION+TAG_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic sendCmd(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [TAG_W-1:0] tag);
    logic accepted;
    accepted = 1'b0;
    CmdA = a; CmdB = b; CmdOp = op; CmdTag = tag; CmdValid = 1'b1;
    for (int i = 0; i < 100 && !accepted; i++) begin
      accepted = CmdReady;
      tick();
    end
    CmdValid = 1'b0;
    check("cmd_accept", 32'(accepted), 32'd1);
  endtask

  task automatic waitRsp();
    for (int i = 0; i < 200 && !RspValid; i++) tick();
    check("rsp_seen", 32'(RspValid), 32'd1);
  endtask

  task automatic expectRsp(input string name, input logic [31:0] res,
                           input logic [TAG_W-1:0] tag, input logic to);
    waitRsp();
    check({name, "_result"}, RspResult, res);
    check({name, "_tag"}, 32'(RspTag), 32'(tag));
    check({name, "_timeout"}, 32'(RspTimeout), 32'(to));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PRECISION+TAG_W-1:0] e;
    logic early;
    int seen;

    tick(); tick();
    check("rst_fpustart", 32'(FpuStart), 0);
    check("rst_rspvalid", 32'(RspValid), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_cmdready", 32'(CmdReady), 1);
    check("rst_fpua", FpuA, 0);
    check("rst_rspresult", RspResult, 0);
    check("rst_rsptag", 32'(RspTag), 0);
    check("rst_rsptimeout", 32'(RspTimeout), 0);
    check("rst_state", 32'(DbgState), 32'(IDLE));
    ResetN = 1'b1;
    tick();

    // add
    RspReady = 1'b1;
    sendCmd(32'h3F800000, 32'h40000000, OP_ADD, 4'd5);
    expectRsp("add", 32'h40400000, 4'd5, 1'b0);

    // mul latency: acceptance at T, RspValid first seen after T+5
    sendCmd(32'h40000000, 32'h40400000, OP_MUL, 4'd8);
    tick();
    check("mul_start_t1", 32'(FpuStart), 1);
    check("mul_fpua", FpuA, 32'h40000000);
    check("mul_fpub", FpuB, 32'h40400000);
    check("mul_fpuop", 32'(FpuOperation), 32'(OP_MUL));
    tick();
    check("mul_start_t2", 32'(FpuStart), 0);
    tick(); tick();
    check("mul_rsp_t4", 32'(RspValid), 0);
    tick();
    check("mul_rsp_t5", 32'(RspValid), 1);
    check("mul_result", RspResult, 32'h40C00000);
    check("mul_tag", 32'(RspTag), 8);
    tick();
    check("mul_rsp_done", 32'(RspValid), 0);

    // sub then div back-to-back, one IDLE bubble between them
    sendCmd(32'h40400000, 32'h3F800000, OP_SUB, 4'd7);
    sendCmd(32'h40C00000, 32'h40000000, OP_DIV, 4'd9);
    expectRsp("sub", 32'h40000000, 4'd7, 1'b0);
    check("bubble_state", 32'(DbgState), 32'(IDLE));
    check("bubble_start", 32'(FpuStart), 0);
    tick();
    check("b2b_start", 32'(FpuStart), 1);
    expectRsp("div", 32'h40400000, 4'd9, 1'b0);

    // backpressure: 5 accepted, 6th refused
    RspReady = 1'b0;
    sendCmd(32'h3F800000, 32'h40000000, OP_ADD, 4'd1); exp_q.push_back({32'h40400000, 4'd1});
    sendCmd(32'h40400000, 32'h3F800000, OP_SUB, 4'd2); exp_q.push_back({32'h40000000, 4'd2});
    sendCmd(32'h40000000, 32'h40400000, OP_MUL, 4'd3); exp_q.push_back({32'h40C00000, 4'd3});
    sendCmd(32'h40C00000, 32'h40000000, OP_DIV, 4'd4); exp_q.push_back({32'h40400000, 4'd4});
    sendCmd(32'h3F800000, 32'h40000000, OP_ADD, 4'd5); exp_q.push_back({32'h40400000, 4'd5});
    CmdA = 32'h40000000; CmdB = 32'h40400000; CmdOp = OP_MUL; CmdTag = 4'd6; CmdValid = 1'b1;
    check("full_cmdready", 32'(CmdReady), 0);
    repeat (12) tick();
    check("full_cmdready_hold", 32'(CmdReady), 0);
    CmdValid = 1'b0;
    RspReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      waitRsp();
      e = exp_q.pop_front();
      check("bp_result", RspResult, e[PRECISION+TAG_W-1:TAG_W]);
      check("bp_tag", 32'(RspTag), 32'(e[TAG_W-1:0]));
      tick();
    end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (RspValid) seen++;
      tick();
    end
    check("bp_no_extra", 32'(seen), 0);
    check("bp_idle_busy", 32'(Busy), 0);

    // Done stuck high: ignored through GUARD, captured on first WAIT edge
    stubMode = 1;
    sendCmd(32'h3F800000, 32'h40000000, OP_ADD, 4'd3);
    early = 1'b0;
    repeat (4) begin
      tick();
      early = early | RspValid;
    end
    check("stuck1_guard", 32'(early), 0);
    tick();
    check("stuck1_rsp_t5", 32'(RspValid), 1);
    check("stuck1_result", RspResult, 32'h0BADF00D);
    check("stuck1_timeout", 32'(RspTimeout), 0);
    check("stuck1_tag", 32'(RspTag), 3);
    tick();

    // Done stuck low: timeout after TIMEOUT wait cycles (edge T+20)
    stubMode = 2;
    sendCmd(32'h3F800000, 32'h40000000, OP_ADD, 4'd6);
    early = 1'b0;
    repeat (19) begin
      tick();
      early = early | RspValid;
    end
    check("stuck0_early", 32'(early), 0);
    tick();
    check("stuck0_rsp", 32'(RspValid), 1);
    check("stuck0_timeout", 32'(RspTimeout), 1);
    check("stuck0_result", RspResult, 0);
    check("stuck0_tag", 32'(RspTag), 6);
    tick();

    // reset during WAIT with two commands queued
    sendCmd(32'h3F800000, 32'h40000000, OP_ADD, 4'd10);
    sendCmd(32'h40400000, 32'h3F800000, OP_SUB, 4'd11);
    sendCmd(32'h40000000, 32'h40400000, OP_MUL, 4'd12);
    repeat (6) tick();
    check("pre_rst_state", 32'(DbgState), 32'(WAIT));
    check("pre_rst_busy", 32'(Busy), 1);
    ResetN = 1'b0;
    #1;
    check("mid_rst_fpustart", 32'(FpuStart), 0);
    check("mid_rst_rspvalid", 32'(RspValid), 0);
    check("mid_rst_busy", 32'(Busy), 0);
    check("mid_rst_cmdready", 32'(CmdReady), 1);
    check("mid_rst_state", 32'(DbgState), 32'(IDLE));
    tick();
    ResetN = 1'b1;
    stubMode = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (RspValid || FpuStart) seen++;
      tick();
    end
    check("flushed_no_rsp", 32'(seen), 0);

    // reset during START drops the load pulse at once
    sendCmd(32'h40000000, 32'h40400000, OP_MUL, 4'd2);
    tick();
    check("start_pre_rst", 32'(FpuStart), 1);
    ResetN = 1'b0;
    #1;
    check("start_rst_drop", 32'(FpuStart), 0);
    tick();
    ResetN = 1'b1;
    tick();

    sendCmd(32'h3F800000, 32'h40000000, OP_ADD, 4'd4);
    expectRsp("post_rst_add", 32'h40400000, 4'd4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
